// File: rtl/rc5_dec_16bit.sv
// rc5_dec_16bit: iterative RC5-8/R decryptor, one half-round per clock.
// Word layout {A,B}; the expanded-key table is a parameter and is fixed at build time.
`default_nettype none

module rc5_dec_16bit #(
  parameter int unsigned            ROUNDS  = 2,
  parameter logic [16*ROUNDS+15:0]  S_TABLE = 48'hD2_33_94_F5_56_B7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dec_start,
  input  logic [15:0] c,
  output logic [15:0] p,
  output logic        dec_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HALF_B = 2'd1,
    HALF_A = 2'd2,
    FINAL  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [15:0] p_q, p_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  // Table padded to 32 entries so a 5-bit {rnd,lsb} index is always in range.
  logic [7:0]  s_tab [32];
  logic [7:0]  s_odd;
  logic [7:0]  s_even;

  for (genvar i = 0; i < 32; i++) begin : g_s_tab
    if (i < 2 * ROUNDS + 2) begin : g_used
      assign s_tab[i] = S_TABLE[8*i +: 8];
    end else begin : g_pad
      assign s_tab[i] = 8'h00;
    end
  end

  assign s_odd  = s_tab[{rnd_q, 1'b1}];
  assign s_even = s_tab[{rnd_q, 1'b0}];

  // Doubling the word makes a rotate by zero fall out naturally.
  function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] n);
    return 8'({v, v} >> n);
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rnd_d   = rnd_q;
    p_d     = p_q;
    done_d  = done_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (dec_start) begin
          a_d     = c[15:8];
          b_d     = c[7:0];
          rnd_d   = 4'(ROUNDS);
          busy_d  = 1'b1;
          state_d = HALF_B;
        end
      end
      HALF_B: begin
        b_d     = rotr8(b_q - s_odd, a_q[2:0]) ^ a_q;
        state_d = HALF_A;
      end
      HALF_A: begin
        a_d     = rotr8(a_q - s_even, b_q[2:0]) ^ b_q;
        rnd_d   = rnd_q - 4'd1;
        state_d = (rnd_q == 4'd1) ? FINAL : HALF_B;
      end
      FINAL: begin
        p_d     = {a_q - s_tab[0], b_q - s_tab[1]};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      rnd_q   <= 4'h0;
      p_q     <= 16'h0000;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rnd_q   <= rnd_d;
      p_q     <= p_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign p        = p_q;
  assign dec_done = done_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rc5_dec_16bit.sv
// tb_rc5_dec_16bit: randomized self-checking bench for rc5_dec_16bit (R=2 and R=1 instances).
`default_nettype none

module tb_rc5_dec_16bit;

  localparam logic [255:0] TAB2 = 256'hD2_33_94_F5_56_B7;
  localparam logic [255:0] TAB1 = 256'h94_F5_56_B7;

  logic        clock = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [15:0] c0, c1, p0, p1;
  logic        done0, done1, busy0, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  rc5_dec_16bit dut0 (
    .clock(clock), .reset(reset), .dec_start(start0), .c(c0),
    .p(p0), .dec_done(done0), .busy(busy0)
  );

  rc5_dec_16bit #(.ROUNDS(1), .S_TABLE(32'h94F556B7)) dut1 (
    .clock(clock), .reset(reset), .dec_start(start1), .c(c1),
    .p(p1), .dec_done(done1), .busy(busy1)
  );

  // ---------------- reference model ----------------
  function automatic int sk(input logic [255:0] t, input int k);
    return int'(8'(t >> (8 * k)));
  endfunction

  function automatic int rotl(input int v, input int n);
    return ((v << n) | (v >> (8 - n))) & 255;
  endfunction

  function automatic int rotr(input int v, input int n);
    return ((v >> n) | (v << (8 - n))) & 255;
  endfunction

  function automatic logic [15:0] rc5_enc(input logic [15:0] pt, input int r, input logic [255:0] t);
    int a, b;
    a = (int'(pt[15:8]) + sk(t, 0)) % 256;
    b = (int'(pt[7:0]) + sk(t, 1)) % 256;
    for (int i = 1; i <= r; i++) begin
      a = (rotl(a ^ b, b % 8) + sk(t, 2 * i)) % 256;
      b = (rotl(b ^ a, a % 8) + sk(t, 2 * i + 1)) % 256;
    end
    return {8'(a), 8'(b)};
  endfunction

  function automatic logic [15:0] rc5_dec(input logic [15:0] ct, input int r, input logic [255:0] t);
    int a, b;
    a = ct[15:8];
    b = ct[7:0];
    for (int i = r; i >= 1; i--) begin
      b = rotr((b - sk(t, 2 * i + 1) + 256) % 256, a % 8) ^ a;
      a = rotr((a - sk(t, 2 * i) + 256) % 256, b % 8) ^ b;
    end
    return {8'((a - sk(t, 0) + 256) % 256), 8'((b - sk(t, 1) + 256) % 256)};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Issue one request on the selected instance; returns p and edges from acceptance to dec_done.
  task automatic run_dec(input bit sel, input logic [15:0] cin, output logic [15:0] pout, output int lat);
    if (sel) begin c1 = cin; start1 = 1'b1; end
    else     begin c0 = cin; start0 = 1'b1; end
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    lat  = -1;
    pout = 16'hxxxx;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((sel ? done1 : done0) === 1'b1) begin
        lat  = i;
        pout = sel ? p1 : p0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    tick();
    checks++;
    if (p0 !== 16'h0000 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: p=%h done=%b busy=%b, required p=0000 done=0 busy=0", p0, done0, busy0);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_roundtrip;
    logic [15:0] pts [$];
    logic [15:0] got, ct;
    int lat;
    pts = '{16'h0000, 16'hFFFF, rc5_dec(16'h0800, 2, TAB2), rc5_dec(16'hF8F8, 2, TAB2)};
    for (int i = 0; i < 8; i++) pts.push_back(16'($urandom));
    foreach (pts[i]) begin
      ct = rc5_enc(pts[i], 2, TAB2);
      run_dec(1'b0, ct, got, lat);
      checks++;
      if (got !== pts[i] || lat != 5) begin
        errors++;
        $display("FAIL roundtrip c=%h: p=%h lat=%0d, required p=%h lat=5", ct, got, lat, pts[i]);
      end
    end
  endtask

  task automatic test_default_vector;
    c0 = 16'hE7E0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busy0 !== 1'b1 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL vector_busy cycle %0d: busy=%b done=%b, required busy=1 done=0", i, busy0, done0);
      end
      tick();
    end
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || p0 !== 16'h0000) begin
      errors++;
      $display("FAIL vector_done: done=%b busy=%b p=%h, required done=1 busy=0 p=0000", done0, busy0, p0);
    end
    tick();
    checks++;
    if (done0 !== 1'b0 || p0 !== 16'h0000) begin
      errors++;
      $display("FAIL vector_pulse: done=%b p=%h, required done=0 p=0000", done0, p0);
    end
  endtask

  task automatic test_rounds1;
    logic [15:0] got, pt, ct;
    int lat;
    run_dec(1'b1, 16'h6DFB, got, lat);
    checks++;
    if (got !== 16'h0000 || lat != 3) begin
      errors++;
      $display("FAIL r1_vector: p=%h lat=%0d, required p=0000 lat=3", got, lat);
    end
    for (int i = 0; i < 4; i++) begin
      pt = 16'($urandom);
      ct = rc5_enc(pt, 1, TAB1);
      run_dec(1'b1, ct, got, lat);
      checks++;
      if (got !== pt || lat != 3) begin
        errors++;
        $display("FAIL r1_roundtrip c=%h: p=%h lat=%0d, required p=%h lat=3", ct, got, lat, pt);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] cq [$];
    int prev = -1;
    int ndone = 0;
    for (int n = 0; n < 40; n++) begin
      c0 = 16'($urandom);
      start0 = 1'b1;
      cq.push_back(c0);
      tick();
      if (done0 === 1'b1) begin
        ndone++;
        checks++;
        if (n < 5) begin
          errors++;
          $display("FAIL b2b_early: done at edge %0d, required none before edge 5", n);
        end else if (p0 !== rc5_dec(cq[n-5], 2, TAB2) || (prev >= 0 && n - prev != 6) || (prev < 0 && n != 5)) begin
          errors++;
          $display("FAIL b2b edge %0d: p=%h gap=%0d, required p=%h gap=6", n, p0, n - prev, rc5_dec(cq[n-5], 2, TAB2));
        end
        prev = n;
      end
    end
    start0 = 1'b0;
    checks++;
    if (ndone != 6) begin
      errors++;
      $display("FAIL b2b_count: %0d completions, required 6", ndone);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_ignore_busy;
    logic [15:0] x;
    int extra = 0;
    x = 16'($urandom);
    c0 = x;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    c0 = ~x;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    c0 = 16'($urandom);
    tick();
    tick();
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_early: done=%b, required 0", done0);
    end
    tick();
    checks++;
    if (done0 !== 1'b1 || p0 !== rc5_dec(x, 2, TAB2)) begin
      errors++;
      $display("FAIL busy_ignore_result: done=%b p=%h, required done=1 p=%h", done0, p0, rc5_dec(x, 2, TAB2));
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done0 === 1'b1 || busy0 === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_ignore_extra: %0d active cycles after completion, required 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] got;
    int lat;
    run_dec(1'b0, 16'h1234, got, lat);
    checks++;
    if (got !== rc5_dec(16'h1234, 2, TAB2) || lat != 5) begin
      errors++;
      $display("FAIL pre_reset_op: p=%h lat=%0d, required p=%h lat=5", got, lat, rc5_dec(16'h1234, 2, TAB2));
    end
    tick();
    c0 = 16'hBEEF;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_before_reset: done=%b busy=%b, required done=0 busy=1", done0, busy0);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (p0 !== 16'h0000 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: p=%h done=%b busy=%b, required p=0000 done=0 busy=0", p0, done0, busy0);
    end
    tick();
    tick();
    reset = 1'b0;
    run_dec(1'b0, 16'hE7E0, got, lat);
    checks++;
    if (got !== 16'h0000 || lat != 5) begin
      errors++;
      $display("FAIL post_reset_op: p=%h lat=%0d, required p=0000 lat=5", got, lat);
    end
  endtask

  task automatic test_reset_with_start;
    c0 = 16'h5A5A;
    start0 = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start0 = 1'b0;
    tick();
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_start: busy=%b done=%b, required busy=0 done=0", busy0, done0);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    c0     = 16'h0000;
    c1     = 16'h0000;
    test_reset();
    test_roundtrip();
    test_default_vector();
    test_rounds1();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_reset_with_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rc5_dec_16bit.md
# rc5_dec_16bit

Iterative RC5-8/R decryptor: recovers a 16-bit plaintext from a 16-bit ciphertext made of two 8-bit words. It uses a fixed expanded-key table, computes one half-round per clock, and signals completion with a single-cycle done pulse. It sits on the receive side of the 16-bit RC5 datapath as the inverse of the 16-bit encryptor, and shares its word layout and key-table convention.

## Interface
- ROUNDS, 2, number of RC5 rounds R; legal range 1..15.
- S_TABLE, 48'hD2_33_94_F5_56_B7, packed expanded-key table of 2R+2 bytes; entry i is at bits [8i+7:8i]. The default is the unmixed magic-constant table for R=2. Any instance with a different ROUNDS must override S_TABLE.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- dec_start  input  1  request; sampled only while idle.
- c  input  16  ciphertext; c[15:8] is word A, c[7:0] is word B; sampled on the accepting edge.
- p  output  16  plaintext, {A,B}; registered and held until the next completion.
- dec_done  output  1  one-cycle pulse; p is valid in the same cycle.
- busy  output  1  high from the accepting edge until the completion edge.

## Operation
- Internal registers: A[7:0], B[7:0], round counter rnd[3:0], state.
- States: IDLE, HALF_B, HALF_A, FINAL.
- IDLE: dec_done is cleared. If dec_start=1, then A<=c[15:8], B<=c[7:0], rnd<=ROUNDS, busy<=1, next state HALF_B.
- HALF_B: B <= ((B - S[2·rnd+1]) rotr A[2:0]) xor A. Next state HALF_A.
- HALF_A: A <= ((A - S[2·rnd]) rotr B[2:0]) xor B, using the B already updated in HALF_B. rnd<=rnd-1. Next state is FINAL if rnd==1, else HALF_B.
- FINAL: p<={A - S[0], B - S[1]}, dec_done<=1, busy<=0, next state IDLE.
- Arithmetic:
  - All additions and subtractions are 8-bit modulo 256; no carry or borrow is kept.
  - Rotate amount is the low 3 bits of the other word. A rotate by 0 leaves the value unchanged and must not produce a shift by 8.
  - The rotate is a true 8-bit rotate, not a shift.
- Table indexing: S[k] = S_TABLE[8k+7:8k], selected by rnd. No out-of-range index is reachable for legal ROUNDS.
- dec_start while busy is ignored. c changes while busy have no effect.
- dec_start held high continuously produces back-to-back decryptions.

## Timing
- Reset (asynchronous assert, any time): state=IDLE, A=B=0, rnd=0, p=16'h0000, dec_done=0, busy=0.
- Reset mid-operation aborts the operation. No dec_done is produced, and p returns to 0.
- Release of reset is synchronous to clock. The first acceptance can occur on the first edge after deassertion.
- Latency: dec_start sampled at edge k; dec_done and the new p appear after edge k+2R+1. For R=2 that is 5 cycles.
- dec_done is high exactly one cycle; p is stable from that cycle on.
- busy is high from after edge k until after edge k+2R+1, which is also when dec_done rises.
- Throughput: if dec_start is high in the dec_done cycle, the next request is accepted on that edge. Start-to-start spacing is 2R+2 cycles.
- dec_start asserted in the same cycle as reset: reset wins and nothing is accepted.

## Test plan
- Default params, c=16'hE7E0, dec_start pulsed one cycle → after 5 cycles p=16'h0000, dec_done high 1 cycle, busy high 5 cycles.
- ROUNDS=1, S_TABLE=32'h94F556B7, c=16'h6DFB → p=16'h0000 after 3 cycles.
- Round-trip: drive 16-bit RC5 encryptor outputs with matching S-table into this block for random p values (including 16'h0000, 16'hFFFF, and words giving rotate amount 0) → recovered p equals the original in every case.
- dec_start held high with c changing every cycle → ciphertexts accepted only every 6 cycles (R=2), and each p matches the c sampled at its accepting edge.
- Assert reset during HALF_A of the first round, then release and issue c=16'hE7E0 → no dec_done before the reset, p=0 after it; the new request completes normally with p=16'h0000.
- Pulse dec_start while busy → ignored, and the in-flight result and timing are unchanged.
